// File: rtl/adder_share_arb_if.sv
// adder_share_arb_if: requester, adder and response signals of the shared-adder arbiter
interface adder_share_arb_if #(
    parameter int NREQ = 4,
    parameter int W    = 64,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_cin;
    logic [W-1:0]      add_s;
    logic              add_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;
    logic              busy;
    modport slave (
        input  req_valid, req_a, req_b, req_cin, add_s, add_cout, rsp_ready,
        output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
    );
    modport master (
        output req_valid, req_a, req_b, req_cin, add_s, add_cout, rsp_ready,
        input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
    );
endinterface

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sequencer sharing one external adder among requesters
module adder_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 64,
    parameter int IDW  = 2
) (
    input logic clk,
    input logic rst,
    adder_share_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cur_id;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           any;
    logic           grant;
    // pick the first valid requester at or after rr_ptr, wrapping; lowest offset wins
    always_comb begin
        win = '0;
        idx = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (bus.req_valid[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end
    assign grant         = any && (state == IDLE || (state == RESP && bus.rsp_ready));
    assign bus.req_ready = grant ? (NREQ'(1) << win) : '0;
    assign bus.busy      = state != IDLE;
    // latch winner operands on grant, capture adder result one cycle later, hold until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cur_id        <= '0;
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.add_cin   <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_cout  <= 1'b0;
            bus.rsp_id    <= '0;
        end else begin
            if (grant) begin
                bus.add_a   <= bus.req_a[int'(win)*W +: W];
                bus.add_b   <= bus.req_b[int'(win)*W +: W];
                bus.add_cin <= bus.req_cin[win];
                cur_id      <= win;
                rr_ptr      <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
            end
            case (state)
                IDLE: state <= grant ? EXEC : IDLE;
                EXEC: begin
                    bus.rsp_sum   <= bus.add_s;
                    bus.rsp_cout  <= bus.add_cout;
                    bus.rsp_id    <= cur_id;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                default: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    state         <= grant ? EXEC : IDLE;
                end
            endcase
        end
    end
endmodule
